reg_bus_responder: RTL and testbench

//  Serves the CPU microcode's CYCLE_REG_FETCH / CYCLE_REG_WRITE requests, decoded from types::reg_type.

---
 rtl/reg_bus_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_reg_bus_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_responder.sv
// reg_bus_responder: serves microcode register fetch/write cycles.
// Owns A, B, TEMPA, TEMPB, X, Y, SP and FLAGS. Maps the memory operands onto nibble RAM.
// Forwards PCSL/PCSH/PCP/NBP/NPP accesses to the fetch unit through ext_sel/ext_we.
// Build option REG_BUS_MEM_WAIT_EN adds a mem_ready input. With it, RAM accesses stall until
// mem_ready is high.
//
// state    | meaning
// IDLE     | ready; a request is accepted here
// REG      | register/ext/constant access completes (resp_valid)
// MEM_RD   | RAM read address presented
// MEM_DATA | RAM read data returned (resp_valid)
// MEM_WR   | RAM write strobe; completes here unless waiting for mem_ready

package types;
    typedef enum logic [1:0] {
        CYCLE_NONE,
        CYCLE_REG_FETCH,
        CYCLE_REG_WRITE
    } microcode_cycle;

    typedef enum logic [4:0] {
        REG_A, REG_B, REG_TEMPA, REG_TEMPB, REG_FLAGS,
        REG_XL, REG_XH, REG_XP, REG_YL, REG_YH, REG_YP,
        REG_SPL, REG_SPH,
        REG_MX, REG_MY, REG_MSP, REG_MSP_DEC, REG_Mn,
        REG_IMM_ADDR_L, REG_IMM_ADDR_H, REG_IMM_ADDR_P,
        REG_IMML, REG_IMMH, REG_HARDCODED_1, REG_ALU, REG_ALU_WITH_FLAGS,
        REG_PCSL, REG_PCSH, REG_PCP, REG_NBP, REG_NPP
    } reg_type;

    typedef enum logic [2:0] {
        REG_INC_NONE,
        REG_XHL,
        REG_YHL,
        REG_SP_INC,
        REG_SP_DEC
    } reg_inc_type;

    typedef enum logic [1:0] {
        IMM_A,
        IMM_B,
        IMM_MX,
        IMM_MY
    } imm_addressed_reg;
endpackage

module reg_bus_responder
    import types::*;
#(
    parameter logic [7:0]  SP_RESET = 8'h00,
    parameter logic [11:0] MN_BASE  = 12'h000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  microcode_cycle req_cycle,
    input  reg_type        req_reg,
    input  reg_inc_type    req_inc,
    input  logic [3:0]     req_wdata,
    input  logic [7:0]     req_imm,
    input  logic [3:0]     alu_result,
    input  logic [3:0]     alu_flags,
    output logic           resp_valid,
    output logic [3:0]     resp_rdata,
    output logic           resp_err,
    output logic [11:0]    mem_addr,
    output logic           mem_we,
    output logic [3:0]     mem_wdata,
    input  logic [3:0]     mem_rdata,
`ifdef REG_BUS_MEM_WAIT_EN
    input  logic           mem_ready,
`endif
    output reg_type        ext_sel,
    output logic           ext_we,
    input  logic [3:0]     ext_rdata,
    output logic [3:0]     a_out,
    output logic [3:0]     b_out,
    output logic [3:0]     tempa_out,
    output logic [3:0]     tempb_out,
    output logic [3:0]     flags_out,
    output logic [11:0]    x_out,
    output logic [11:0]    y_out,
    output logic [7:0]     sp_out
);

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MEM_RD,
        MEM_DATA,
        MEM_WR
    } state_t;

`ifdef REG_BUS_MEM_WAIT_EN
    localparam bit MEM_WAIT = 1'b1;
    logic mem_go;
    assign mem_go = mem_ready;
`else
    localparam bit MEM_WAIT = 1'b0;
    logic mem_go;
    assign mem_go = 1'b1;
`endif

    state_t         state_q, state_d;
    logic [3:0]     a_q, a_d, b_q, b_d, tempa_q, tempa_d, tempb_q, tempb_d, flags_q, flags_d;
    logic [11:0]    x_q, x_d, y_q, y_d;
    logic [7:0]     sp_q, sp_d;
    logic [3:0]     rdata_q, rdata_d;
    logic [3:0]     wdata_q, wdata_d;
    logic [11:0]    addr_q, addr_d;
    reg_type        reg_q, reg_d;
    microcode_cycle cycle_q, cycle_d;
    reg_inc_type    inc_q, inc_d;

    reg_type        eff_reg;
    logic [11:0]    eff_addr;
    logic [3:0]     fetch_val;
    logic           accept;
    logic           active_cycle;
    logic           upd_now;
    reg_inc_type    upd_inc;

    function automatic logic is_mem(input reg_type r);
        return r inside {REG_MX, REG_MY, REG_MSP, REG_MSP_DEC, REG_Mn};
    endfunction

    function automatic logic is_ro(input reg_type r);
        return r inside {REG_ALU, REG_ALU_WITH_FLAGS, REG_IMML, REG_IMMH, REG_HARDCODED_1};
    endfunction

    function automatic logic is_ext(input reg_type r);
        return r inside {REG_PCSL, REG_PCSH, REG_PCP, REG_NBP, REG_NPP};
    endfunction

    function automatic reg_type imm_to_reg(input imm_addressed_reg i);
        case (i)
            IMM_A:   return REG_A;
            IMM_B:   return REG_B;
            IMM_MX:  return REG_MX;
            default: return REG_MY;
        endcase
    endfunction

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid && req_ready;
    assign active_cycle = (req_cycle == CYCLE_REG_FETCH) || (req_cycle == CYCLE_REG_WRITE);

    // Resolve immediate-addressed operands to a concrete register at accept time
    always_comb begin
        eff_reg = req_reg;
        case (req_reg)
            REG_IMM_ADDR_L: eff_reg = imm_to_reg(imm_addressed_reg'(req_imm[1:0]));
            REG_IMM_ADDR_H: eff_reg = imm_to_reg(imm_addressed_reg'(req_imm[3:2]));
            REG_IMM_ADDR_P: eff_reg = imm_to_reg(imm_addressed_reg'(req_imm[5:4]));
            default:        eff_reg = req_reg;
        endcase
    end

    // RAM address of a memory operand, using register values before any post-update
    always_comb begin
        eff_addr = 12'h000;
        case (eff_reg)
            REG_MX:      eff_addr = x_q;
            REG_MY:      eff_addr = y_q;
            REG_MSP:     eff_addr = {4'h0, sp_q};
            REG_MSP_DEC: eff_addr = {4'h0, sp_q - 8'd1};
            REG_Mn:      eff_addr = MN_BASE | {8'h00, req_imm[3:0]};
            default:     eff_addr = 12'h000;
        endcase
    end

    // Fetch value for register, constant and fetch-unit sources
    always_comb begin
        fetch_val = 4'h0;
        case (eff_reg)
            REG_A:              fetch_val = a_q;
            REG_B:              fetch_val = b_q;
            REG_TEMPA:          fetch_val = tempa_q;
            REG_TEMPB:          fetch_val = tempb_q;
            REG_FLAGS:          fetch_val = flags_q;
            REG_XL:             fetch_val = x_q[3:0];
            REG_XH:             fetch_val = x_q[7:4];
            REG_XP:             fetch_val = x_q[11:8];
            REG_YL:             fetch_val = y_q[3:0];
            REG_YH:             fetch_val = y_q[7:4];
            REG_YP:             fetch_val = y_q[11:8];
            REG_SPL:            fetch_val = sp_q[3:0];
            REG_SPH:            fetch_val = sp_q[7:4];
            REG_IMML:           fetch_val = req_imm[3:0];
            REG_IMMH:           fetch_val = req_imm[7:4];
            REG_HARDCODED_1:    fetch_val = 4'd1;
            REG_ALU:            fetch_val = alu_result;
            REG_ALU_WITH_FLAGS: fetch_val = alu_result;
            REG_PCSL, REG_PCSH, REG_PCP, REG_NBP, REG_NPP: fetch_val = ext_rdata;
            default:            fetch_val = 4'h0;
        endcase
    end

    // Next state, plus when and which post-update lands (on the edge entering completion)
    always_comb begin
        state_d = state_q;
        upd_now = 1'b0;
        upd_inc = inc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (active_cycle && is_mem(eff_reg)) begin
                        if (req_cycle == CYCLE_REG_FETCH) begin
                            state_d = MEM_RD;
                        end else begin
                            state_d = MEM_WR;
                            upd_now = !MEM_WAIT;
                            upd_inc = req_inc;
                        end
                    end else begin
                        state_d = REG;
                        upd_now = active_cycle;
                        upd_inc = req_inc;
                    end
                end
            end
            REG:      state_d = IDLE;
            MEM_RD: begin
                if (mem_go) begin
                    state_d = MEM_DATA;
                    upd_now = 1'b1;
                end
            end
            MEM_DATA: state_d = IDLE;
            MEM_WR: begin
                if (!MEM_WAIT) begin
                    state_d = IDLE;
                end else if (mem_go) begin
                    state_d = REG;
                    upd_now = 1'b1;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // Register file writes, fetch data capture and post-updates (post-update overrides a write)
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        tempa_d = tempa_q;
        tempb_d = tempb_q;
        flags_d = flags_q;
        x_d     = x_q;
        y_d     = y_q;
        sp_d    = sp_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        cycle_d = cycle_q;
        inc_d   = inc_q;

        if (accept) begin
            reg_d   = eff_reg;
            cycle_d = req_cycle;
            inc_d   = req_inc;
            wdata_d = req_wdata;
            addr_d  = eff_addr;
            if (req_cycle == CYCLE_REG_FETCH && !is_mem(eff_reg)) begin
                rdata_d = fetch_val;
                if (eff_reg == REG_ALU_WITH_FLAGS) begin
                    flags_d = alu_flags;
                end
            end
            if (req_cycle == CYCLE_REG_WRITE && !is_mem(eff_reg)) begin
                case (eff_reg)
                    REG_A:     a_d        = req_wdata;
                    REG_B:     b_d        = req_wdata;
                    REG_TEMPA: tempa_d    = req_wdata;
                    REG_TEMPB: tempb_d    = req_wdata;
                    REG_FLAGS: flags_d    = req_wdata;
                    REG_XL:    x_d[3:0]   = req_wdata;
                    REG_XH:    x_d[7:4]   = req_wdata;
                    REG_XP:    x_d[11:8]  = req_wdata;
                    REG_YL:    y_d[3:0]   = req_wdata;
                    REG_YH:    y_d[7:4]   = req_wdata;
                    REG_YP:    y_d[11:8]  = req_wdata;
                    REG_SPL:   sp_d[3:0]  = req_wdata;
                    REG_SPH:   sp_d[7:4]  = req_wdata;
                    default:   ;
                endcase
            end
        end

        if (state_q == MEM_DATA) begin
            rdata_d = mem_rdata;
        end

        if (upd_now) begin
            case (upd_inc)
                REG_XHL:    x_d  = {x_q[11:8], x_q[7:0] + 8'd1};
                REG_YHL:    y_d  = {y_q[11:8], y_q[7:0] + 8'd1};
                REG_SP_INC: sp_d = sp_q + 8'd1;
                REG_SP_DEC: sp_d = sp_q - 8'd1;
                default:    ;
            endcase
        end
    end

    // State and register flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            tempa_q <= 4'h0;
            tempb_q <= 4'h0;
            flags_q <= 4'h0;
            x_q     <= 12'h000;
            y_q     <= 12'h000;
            sp_q    <= SP_RESET;
            rdata_q <= 4'h0;
            wdata_q <= 4'h0;
            addr_q  <= 12'h000;
            reg_q   <= REG_A;
            cycle_q <= CYCLE_NONE;
            inc_q   <= REG_INC_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tempa_q <= tempa_d;
            tempb_q <= tempb_d;
            flags_q <= flags_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sp_q    <= sp_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            cycle_q <= cycle_d;
            inc_q   <= inc_d;
        end
    end

    // Strobes are gated by reset so an aborted access drops them in the reset cycle itself
    always_comb begin
        resp_valid = !reset && ((state_q == REG) || (state_q == MEM_DATA) ||
                                ((state_q == MEM_WR) && !MEM_WAIT));
        resp_err   = !reset && (state_q == REG) && (cycle_q == CYCLE_REG_WRITE) && is_ro(reg_q);
        mem_we     = !reset && (state_q == MEM_WR);
        ext_we     = !reset && (state_q == REG) && (cycle_q == CYCLE_REG_WRITE) && is_ext(reg_q);
        resp_rdata = (state_q == MEM_DATA) ? mem_rdata : rdata_q;
        ext_sel    = (state_q == IDLE) ? req_reg : reg_q;
    end

    // The write nibble is shared between RAM and the fetch unit
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign tempa_out = tempa_q;
    assign tempb_out = tempb_q;
    assign flags_out = flags_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign sp_out    = sp_q;

endmodule

// File: tb/tb_reg_bus_responder.sv
// Scoreboard bench for reg_bus_responder: directed requests push expected responses,
// monitors compare responses and RAM writes as they appear.
module tb_reg_bus_responder;
    import types::*;

    localparam logic [7:0]  SP_RST = 8'h40;
    localparam logic [11:0] MN_B   = 12'h300;
    localparam int K_NONE = 0, K_A = 1, K_B = 2, K_X = 3, K_Y = 4, K_SP = 5, K_F = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    microcode_cycle req_cycle;
    reg_type        req_reg;
    reg_inc_type    req_inc;
    logic [3:0]     req_wdata;
    logic [7:0]     req_imm;
    logic [3:0]     alu_result, alu_flags;
    logic           resp_valid, resp_err;
    logic [3:0]     resp_rdata;
    logic [11:0]    mem_addr;
    logic           mem_we;
    logic [3:0]     mem_wdata, mem_rdata;
    reg_type        ext_sel;
    logic           ext_we;
    logic [3:0]     ext_rdata;
    logic [3:0]     a_out, b_out, tempa_out, tempb_out, flags_out;
    logic [11:0]    x_out, y_out;
    logic [7:0]     sp_out;
`ifdef REG_BUS_MEM_WAIT_EN
    logic           mem_ready = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int id_ctr = 0;

    typedef struct {
        int         id;
        bit         chk_rd;
        logic [3:0] rdata;
        logic       err;
        int         lat;
        int         acc;
        int         kind;
        logic [11:0] val;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  data;
    } wexp_t;

    exp_t  exp_q[$];
    wexp_t wexp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_responder #(.SP_RESET(SP_RST), .MN_BASE(MN_B)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cycle(req_cycle), .req_reg(req_reg), .req_inc(req_inc),
        .req_wdata(req_wdata), .req_imm(req_imm),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef REG_BUS_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .ext_sel(ext_sel), .ext_we(ext_we), .ext_rdata(ext_rdata),
        .a_out(a_out), .b_out(b_out), .tempa_out(tempa_out), .tempb_out(tempb_out),
        .flags_out(flags_out), .x_out(x_out), .y_out(y_out), .sp_out(sp_out)
    );

    // RAM model: one-cycle read latency, preloaded while reset is high
    logic [3:0] mem [0:4095];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 4'h0;
            mem[12'hAFF] <= 4'h3;
            mem[12'hA00] <= 4'hE;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Fetch-unit register model
    always_comb begin
        ext_rdata = 4'h0;
        case (ext_sel)
            REG_PCSL: ext_rdata = 4'hC;
            REG_PCSH: ext_rdata = 4'h5;
            REG_PCP:  ext_rdata = 4'h7;
            default:  ext_rdata = 4'h0;
        endcase
    end

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [11:0] obs(input int k);
        case (k)
            K_A:     return {8'h00, a_out};
            K_B:     return {8'h00, b_out};
            K_X:     return x_out;
            K_Y:     return y_out;
            K_SP:    return {4'h0, sp_out};
            K_F:     return {8'h00, flags_out};
            default: return 12'h000;
        endcase
    endfunction

    task automatic do_req(input microcode_cycle c, input reg_type r, input reg_inc_type inc,
                          input logic [3:0] wd, input logic [7:0] imm, input bit push,
                          input bit chk_rd, input logic [3:0] rd, input logic er,
                          input int lat, input int kind, input logic [11:0] val);
        exp_t e;
        int   t;
        @(negedge clk);
        req_valid = 1'b1;
        req_cycle = c;
        req_reg   = r;
        req_inc   = inc;
        req_wdata = wd;
        req_imm   = imm;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 required 1 within 100 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cycle = CYCLE_NONE;
        if (push) begin
            id_ctr++;
            e.id = id_ctr; e.chk_rd = chk_rd; e.rdata = rd; e.err = er;
            e.lat = lat; e.acc = cyc; e.kind = kind; e.val = val;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input reg_type r, input reg_inc_type inc, input logic [3:0] wd,
                      input logic [7:0] imm, input logic er, input int lat,
                      input int kind, input logic [11:0] val);
        do_req(CYCLE_REG_WRITE, r, inc, wd, imm, 1'b1, 1'b0, 4'h0, er, lat, kind, val);
    endtask

    task automatic fe(input reg_type r, input reg_inc_type inc, input logic [7:0] imm,
                      input logic [3:0] rd, input int lat, input int kind, input logic [11:0] val);
        do_req(CYCLE_REG_FETCH, r, inc, 4'h0, imm, 1'b1, 1'b1, rd, 1'b0, lat, kind, val);
    endtask

    task automatic push_w(input logic [11:0] a, input logic [3:0] d);
        wexp_t w;
        w.addr = a;
        w.data = d;
        wexp_q.push_back(w);
    endtask

    // Response monitor
    initial begin : resp_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h err=%b required no response",
                             resp_rdata, resp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_rd) check($sformatf("resp%0d_rdata", e.id), {8'h00, resp_rdata}, {8'h00, e.rdata});
                    check($sformatf("resp%0d_err", e.id), {11'h000, resp_err}, {11'h000, e.err});
                    check($sformatf("resp%0d_latency", e.id), 12'(cyc - e.acc + 1), 12'(e.lat));
                    if (e.kind != K_NONE) begin
                        @(negedge clk);
                        check($sformatf("resp%0d_reg%0d", e.id, e.kind), obs(e.kind), e.val);
                    end
                end
            end
        end
    end

    // RAM write monitor: one expected entry per mem_we cycle
    initial begin : wr_mon
        wexp_t w;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (wexp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_mem_we: got write addr=%h data=%h required none",
                             mem_addr, mem_wdata);
                end else begin
                    w = wexp_q.pop_front();
                    check("mem_we_addr", mem_addr, w.addr);
                    check("mem_we_data", {8'h00, mem_wdata}, {8'h00, w.data});
                end
            end
        end
    end

    initial begin : stim
        int t;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cycle  = CYCLE_NONE;
        req_reg    = REG_A;
        req_inc    = REG_INC_NONE;
        req_wdata  = 4'h0;
        req_imm    = 8'h00;
        alu_result = 4'h0;
        alu_flags  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {11'h0, req_ready}, 12'h001);
        check("rst_resp_valid", {11'h0, resp_valid}, 12'h000);
        check("rst_mem_we", {11'h0, mem_we}, 12'h000);
        check("rst_rdata", {8'h0, resp_rdata}, 12'h000);
        check("rst_a", {8'h0, a_out}, 12'h000);
        check("rst_x", x_out, 12'h000);
        check("rst_sp", {4'h0, sp_out}, {4'h0, SP_RST});
        reset = 1'b0;

        wr(REG_A, REG_INC_NONE, 4'h9, 8'h00, 1'b0, 1, K_A, 12'h009);
        fe(REG_A, REG_INC_NONE, 8'h00, 4'h9, 1, K_NONE, 12'h0);

        wr(REG_XP, REG_INC_NONE, 4'hA, 8'h00, 1'b0, 1, K_NONE, 12'h0);
        wr(REG_XH, REG_INC_NONE, 4'hF, 8'h00, 1'b0, 1, K_NONE, 12'h0);
        wr(REG_XL, REG_INC_NONE, 4'hF, 8'h00, 1'b0, 1, K_X, 12'hAFF);
        fe(REG_MX, REG_XHL, 8'h00, 4'h3, 2, K_X, 12'hA00);

        wr(REG_SPL, REG_INC_NONE, 4'h0, 8'h00, 1'b0, 1, K_SP, 12'h040);
        wr(REG_SPH, REG_INC_NONE, 4'h0, 8'h00, 1'b0, 1, K_SP, 12'h000);
        push_w(12'h0FF, 4'h5);
        wr(REG_MSP_DEC, REG_SP_DEC, 4'h5, 8'h00, 1'b0, 1, K_SP, 12'h0FF);

        wr(REG_IMM_ADDR_H, REG_INC_NONE, 4'h7, 8'h04, 1'b0, 1, K_B, 12'h007);
        fe(REG_A, REG_INC_NONE, 8'h00, 4'h9, 1, K_A, 12'h009);
        wr(REG_HARDCODED_1, REG_INC_NONE, 4'h1, 8'h00, 1'b1, 1, K_A, 12'h009);

        alu_result = 4'h2;
        alu_flags  = 4'b0101;
        fe(REG_ALU_WITH_FLAGS, REG_INC_NONE, 8'h00, 4'h2, 1, K_F, 12'h005);

        fe(REG_HARDCODED_1, REG_INC_NONE, 8'h00, 4'h1, 1, K_NONE, 12'h0);
        fe(REG_IMMH, REG_INC_NONE, 8'hB6, 4'hB, 1, K_NONE, 12'h0);
        fe(REG_IMM_ADDR_L, REG_INC_NONE, 8'h02, 4'hE, 2, K_X, 12'hA00);

        push_w(12'h30D, 4'h6);
        wr(REG_Mn, REG_INC_NONE, 4'h6, 8'h2D, 1'b0, 1, K_NONE, 12'h0);
        fe(REG_Mn, REG_INC_NONE, 8'h0D, 4'h6, 2, K_NONE, 12'h0);

        fe(REG_MSP, REG_SP_INC, 8'h00, 4'h5, 2, K_SP, 12'h000);
        fe(REG_PCSL, REG_INC_NONE, 8'h00, 4'hC, 1, K_NONE, 12'h0);

        wr(REG_YP, REG_INC_NONE, 4'h5, 8'h00, 1'b0, 1, K_NONE, 12'h0);
        wr(REG_YH, REG_INC_NONE, 4'hF, 8'h00, 1'b0, 1, K_NONE, 12'h0);
        wr(REG_YL, REG_INC_NONE, 4'hF, 8'h00, 1'b0, 1, K_Y, 12'h5FF);
        wr(REG_TEMPA, REG_YHL, 4'h3, 8'h00, 1'b0, 1, K_Y, 12'h500);
        push_w(12'h500, 4'h8);
        wr(REG_IMM_ADDR_P, REG_INC_NONE, 4'h8, 8'h30, 1'b0, 1, K_NONE, 12'h0);

        // Abort a RAM fetch with reset while it sits in MEM_RD
        do_req(CYCLE_REG_FETCH, REG_MX, REG_XHL, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 0, K_NONE, 12'h0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_resp_valid_in_reset", {11'h0, resp_valid}, 12'h000);
        @(posedge clk);
        @(negedge clk);
        check("abort_req_ready", {11'h0, req_ready}, 12'h001);
        check("abort_resp_valid", {11'h0, resp_valid}, 12'h000);
        check("abort_sp", {4'h0, sp_out}, {4'h0, SP_RST});
        check("abort_x", x_out, 12'h000);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        t = 0;
        while ((exp_q.size() != 0 || wexp_q.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("resp_queue_drained", 12'(exp_q.size()), 12'h000);
        check("memwr_queue_drained", 12'(wexp_q.size()), 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
